// File: rtl/grid_scanout_pkg.sv
// grid_scanout_pkg
//   Shared definitions for the 64-bit game grid and its scan-out logic.
//   The grid holds 16 cells of 4-bit exponents, row-major, with cell i at
//   grid[i*4 +: 4]. A value of 0 means the cell is empty.
//   Contents:
//     GRID_CELLS, CELL_W, GRID_W     grid shape
//     DEF_GRID_X0, DEF_GRID_Y0,
//     DEF_TILE_SHIFT, DEF_BORDER     default screen geometry
//     cell_get(grid, idx)            extracts one cell; grid writers use it too
package grid_scanout_pkg;

  localparam int GRID_CELLS = 16;
  localparam int CELL_W     = 4;
  localparam int GRID_W     = GRID_CELLS * CELL_W;

  localparam int DEF_GRID_X0    = 192;
  localparam int DEF_GRID_Y0    = 112;
  localparam int DEF_TILE_SHIFT = 6;
  localparam int DEF_BORDER     = 2;

  function automatic logic [CELL_W-1:0] cell_get(input logic [GRID_W-1:0] g,
                                                 input logic [3:0]        idx);
    return g[int'(idx)*CELL_W +: CELL_W];
  endfunction

endpackage

// File: rtl/grid_snapshot.sv
// grid_snapshot
//   Holds a per-frame copy of the live grid so that pixel lookups never see
//   a half-updated board. The copy is taken only on a vsync pulse. The copy
//   it replaces is kept as well, which lets the scan-out flag cells whose
//   value changed between the two frames.
//   Ports:
//     clk, rst             clock and asynchronous active-high reset
//     vsync_rising_edge    one-cycle frame-start pulse; triggers a snapshot
//     grid                 live game grid
//     snap                 grid as captured at the latest pulse
//     prev_snap            grid as captured at the pulse before that one
//     snap_pulse           high for one cycle after each snapshot
module grid_snapshot
  import grid_scanout_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync_rising_edge,
  input  logic [GRID_W-1:0] grid,
  output logic [GRID_W-1:0] snap,
  output logic [GRID_W-1:0] prev_snap,
  output logic              snap_pulse
);

  // NOTE: snap and prev_snap are data registers, but they are still reset.
  // Until the first vsync, lookups must return an all-zero board, not
  // power-up garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      prev_snap  <= '0;
      snap_pulse <= 1'b0;
    end else begin
      snap_pulse <= vsync_rising_edge;
      if (vsync_rising_edge) begin
        // NOTE: non-blocking assignments make prev_snap take the old snap in
        // this edge. A blocking assignment would copy the new grid into both.
        prev_snap <= snap;
        snap      <= grid;
      end
    end
  end

endmodule

// File: rtl/grid_scanout.sv
// grid_scanout
//   Read-side consumer of the game grid. It maps each incoming pixel
//   coordinate to its grid cell, tile exponent, intra-tile offset and border
//   flag. It uses a fixed two-stage pipeline: one result per cycle, no stalls.
//   Lookups read the per-frame snapshot held in grid_snapshot.
//   Ports:
//     clk, rst             clock and asynchronous active-high reset
//     vsync_rising_edge    frame-start pulse; takes a grid snapshot
//     grid                 live game grid (16 x 4-bit exponents)
//     pix_valid, x, y      pixel coordinate in the active display area
//     tile_valid           pixel lies inside the grid (2-cycle latency)
//     cell_idx             row*4+col of the pixel's cell
//     tile_exp             snapshot exponent of that cell
//     tile_u, tile_v       offsets of the pixel within its tile
//     border               pixel lies in the tile's border band
//     changed              cell differs from the previous snapshot
//     snap_pulse           one-cycle pulse the cycle after a snapshot
//   When tile_valid is 0, every other tile output is forced to 0.
module grid_scanout
  import grid_scanout_pkg::*;
#(
  parameter int GRID_X0    = DEF_GRID_X0,
  parameter int GRID_Y0    = DEF_GRID_Y0,
  parameter int TILE_SHIFT = DEF_TILE_SHIFT,
  parameter int BORDER     = DEF_BORDER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync_rising_edge,
  input  logic [GRID_W-1:0]     grid,
  input  logic                  pix_valid,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  output logic                  tile_valid,
  output logic [3:0]            cell_idx,
  output logic [CELL_W-1:0]     tile_exp,
  output logic [TILE_SHIFT-1:0] tile_u,
  output logic [TILE_SHIFT-1:0] tile_v,
  output logic                  border,
  output logic                  changed,
  output logic                  snap_pulse
);

  localparam int GRID_PX = 4 << TILE_SHIFT;
  localparam int OFS_W   = TILE_SHIFT + 2;

  // The bounds are 11 bits wide so that the upper bound cannot wrap.
  localparam logic [10:0] X_LO = 11'(GRID_X0);
  localparam logic [10:0] X_HI = 11'(GRID_X0 + GRID_PX);
  localparam logic [10:0] Y_LO = 11'(GRID_Y0);
  localparam logic [10:0] Y_HI = 11'(GRID_Y0 + GRID_PX);

  localparam logic [TILE_SHIFT-1:0] B_LO = TILE_SHIFT'(BORDER);
  localparam logic [TILE_SHIFT-1:0] B_HI = TILE_SHIFT'((1 << TILE_SHIFT) - BORDER);

  logic [GRID_W-1:0] snap;
  logic [GRID_W-1:0] prev_snap;

  grid_snapshot u_snapshot (
    .clk               (clk),
    .rst               (rst),
    .vsync_rising_edge (vsync_rising_edge),
    .grid              (grid),
    .snap              (snap),
    .prev_snap         (prev_snap),
    .snap_pulse        (snap_pulse)
  );

  // ---------------- Stage 1: grid-relative coordinates ----------------
  // Only the row/col and offset bits of the difference are ever used. The
  // low bits of a subtraction depend only on the low bits of its operands.
  // When x or y is below the grid origin the difference wraps, but in_grid
  // masks that result.
  logic [OFS_W-1:0] rx, ry;
  logic             in_grid;

  assign rx = x[OFS_W-1:0] - X_LO[OFS_W-1:0];
  assign ry = y[OFS_W-1:0] - Y_LO[OFS_W-1:0];
  assign in_grid = pix_valid &&
                   ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                   ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);

  logic                  s1_valid;
  logic [1:0]            s1_row, s1_col;
  logic [TILE_SHIFT-1:0] s1_u, s1_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_u     <= '0;
      s1_v     <= '0;
    end else begin
      s1_valid <= in_grid;
      s1_col   <= rx[TILE_SHIFT +: 2];
      s1_row   <= ry[TILE_SHIFT +: 2];
      s1_u     <= rx[TILE_SHIFT-1:0];
      s1_v     <= ry[TILE_SHIFT-1:0];
    end
  end

  // ---------------- Stage 2: cell lookup and border ----------------
  // snap is read here before this edge can update it. A lookup in the same
  // cycle as a vsync pulse therefore sees the previous frame's snapshot.
  logic [3:0]            nxt_idx;
  logic [CELL_W-1:0]     nxt_exp;
  logic [TILE_SHIFT-1:0] nxt_u, nxt_v;
  logic                  nxt_border, nxt_changed;

  // NOTE: every signal gets a default value first. No path through the
  // block leaves a signal unassigned, so no latch is inferred.
  always_comb begin
    nxt_idx     = '0;
    nxt_exp     = '0;
    nxt_u       = '0;
    nxt_v       = '0;
    nxt_border  = 1'b0;
    nxt_changed = 1'b0;
    if (s1_valid) begin
      nxt_idx     = {s1_row, s1_col};
      nxt_exp     = cell_get(snap, {s1_row, s1_col});
      nxt_changed = cell_get(snap, {s1_row, s1_col}) !=
                    cell_get(prev_snap, {s1_row, s1_col});
      nxt_u       = s1_u;
      nxt_v       = s1_v;
      nxt_border  = (s1_u < B_LO) || (s1_u >= B_HI) ||
                    (s1_v < B_LO) || (s1_v >= B_HI);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_valid <= 1'b0;
      cell_idx   <= '0;
      tile_exp   <= '0;
      tile_u     <= '0;
      tile_v     <= '0;
      border     <= 1'b0;
      changed    <= 1'b0;
    end else begin
      tile_valid <= s1_valid;
      cell_idx   <= nxt_idx;
      tile_exp   <= nxt_exp;
      tile_u     <= nxt_u;
      tile_v     <= nxt_v;
      border     <= nxt_border;
      changed    <= nxt_changed;
    end
  end

endmodule

// File: tb/tb_grid_scanout.sv
// tb_grid_scanout
//   Self-checking bench for grid_scanout. The reference model works from
//   the pixel-geometry rules directly: integer division and modulo on
//   screen coordinates. It keeps a pair of cell arrays for the current and
//   previous frame snapshots.
module tb_grid_scanout;

  localparam int X0   = 192;
  localparam int Y0   = 112;
  localparam int TILE = 64;
  localparam int BW   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_rising_edge = 1'b0;
  logic [63:0] grid = '0;
  logic        pix_valid = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        tile_valid;
  logic [3:0]  cell_idx;
  logic [3:0]  tile_exp;
  logic [5:0]  tile_u;
  logic [5:0]  tile_v;
  logic        border;
  logic        changed;
  logic        snap_pulse;

  grid_scanout dut (
    .clk               (clk),
    .rst               (rst),
    .vsync_rising_edge (vsync_rising_edge),
    .grid              (grid),
    .pix_valid         (pix_valid),
    .x                 (x),
    .y                 (y),
    .tile_valid        (tile_valid),
    .cell_idx          (cell_idx),
    .tile_exp          (tile_exp),
    .tile_u            (tile_u),
    .tile_v            (tile_v),
    .border            (border),
    .changed           (changed),
    .snap_pulse        (snap_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic tv;
    int   idx;
    int   exp_v;
    int   u;
    int   v;
    logic bd;
    logic ch;
    logic sp;
  } exp_t;

  int   m_snap[16];
  int   m_prev[16];
  logic p_pv;
  int   p_x, p_y;
  exp_t e;

  logic [22:0] got;
  assign got = {tile_valid, cell_idx, tile_exp, tile_u, tile_v, border, changed};

  function automatic exp_t predict(logic pv, int px, int py);
    exp_t r;
    r = '{default: 0};
    if (pv && px >= X0 && px < X0 + 4*TILE && py >= Y0 && py < Y0 + 4*TILE) begin
      r.tv    = 1'b1;
      r.u     = (px - X0) % TILE;
      r.v     = (py - Y0) % TILE;
      r.idx   = ((py - Y0) / TILE) * 4 + (px - X0) / TILE;
      r.exp_v = m_snap[r.idx];
      r.ch    = (m_snap[r.idx] != m_prev[r.idx]);
      r.bd    = (r.u < BW) || (r.u >= TILE - BW) || (r.v < BW) || (r.v >= TILE - BW);
    end
    return r;
  endfunction

  function automatic logic [22:0] pack(exp_t r);
    return {r.tv, 4'(r.idx), 4'(r.exp_v), 6'(r.u), 6'(r.v), r.bd, r.ch};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_snap[i] = 0;
      m_prev[i] = 0;
    end
    p_pv = 1'b0;
    p_x  = 0;
    p_y  = 0;
    e    = '{default: 0};
  endtask

  // Advances one clock and updates the model. Afterwards, e holds the
  // outputs expected just after that edge. Inputs are stable around the
  // edge and change only after the #1.
  task automatic tick();
    @(posedge clk);
    e    = predict(p_pv, p_x, p_y);
    e.sp = vsync_rising_edge;
    if (vsync_rising_edge) begin
      for (int i = 0; i < 16; i++) begin
        m_prev[i] = m_snap[i];
        m_snap[i] = int'(grid[i*4 +: 4]);
      end
    end
    p_pv = pix_valid;
    p_x  = int'(x);
    p_y  = int'(y);
    #1;
  endtask

  task automatic set_pix(logic pv, int px, int py);
    pix_valid = pv;
    x = 10'(px);
    y = 10'(py);
  endtask

  task automatic set_cell(int c, int v);
    grid[c*4 +: 4] = 4'(v);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_clear();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({got, snap_pulse} !== 24'd0) begin
      errors++;
      $display("FAIL reset_initial got %h want 0", {got, snap_pulse});
    end
    @(negedge clk);
    rst = 1'b0;
    // Load a nonzero board and run live pixels through the pipeline.
    for (int i = 0; i < 16; i++) set_cell(i, i + 1);
    vsync_rising_edge = 1'b1;
    tick();
    vsync_rising_edge = 1'b0;
    set_pix(1'b1, X0 + 70, Y0 + 70);
    repeat (3) tick();
    checks++;
    if (tile_valid !== 1'b1 || tile_exp !== 4'd6) begin
      errors++;
      $display("FAIL reset_prestate got tv=%0b exp=%0d want tv=1 exp=6", tile_valid, tile_exp);
    end
    // Assert reset mid-cycle with a valid in-grid pixel still applied.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({got, snap_pulse} !== 24'd0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", {got, snap_pulse});
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (tile_valid !== 1'b1 || cell_idx !== 4'd5 || tile_exp !== 4'd0) begin
      errors++;
      $display("FAIL reset_snap_cleared got tv=%0b idx=%0d exp=%0d want tv=1 idx=5 exp=0",
               tile_valid, cell_idx, tile_exp);
    end
  endtask

  task automatic test_snapshot_isolation();
    set_pix(1'b0, 0, 0);
    grid = '0;
    vsync_rising_edge = 1'b1;
    tick();
    vsync_rising_edge = 1'b0;
    checks++;
    if (snap_pulse !== 1'b1) begin
      errors++;
      $display("FAIL snap_pulse_high got %0b want 1", snap_pulse);
    end
    set_cell(5, 11);
    set_pix(1'b1, X0 + 64 + 10, Y0 + 64 + 10);
    tick();
    checks++;
    if (snap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL snap_pulse_one_cycle got %0b want 0", snap_pulse);
    end
    tick();
    checks++;
    if (cell_idx !== 4'd5 || tile_exp !== 4'd0) begin
      errors++;
      $display("FAIL isolation_no_pulse got idx=%0d exp=%0d want idx=5 exp=0", cell_idx, tile_exp);
    end
    set_pix(1'b0, 0, 0);
    vsync_rising_edge = 1'b1;
    tick();
    vsync_rising_edge = 1'b0;
    set_pix(1'b1, X0 + 64 + 10, Y0 + 64 + 10);
    repeat (2) tick();
    checks++;
    if ({tile_valid, cell_idx, tile_exp, tile_u, tile_v, changed} !==
        {1'b1, 4'd5, 4'd11, 6'd10, 6'd10, 1'b1}) begin
      errors++;
      $display("FAIL isolation_after_pulse got tv=%0b idx=%0d exp=%0d u=%0d v=%0d ch=%0b want 1 5 11 10 10 1",
               tile_valid, cell_idx, tile_exp, tile_u, tile_v, changed);
    end
  endtask

  task automatic test_latency();
    set_pix(1'b0, 0, 0);
    repeat (2) tick();
    set_pix(1'b1, X0 + 5, Y0 + 5);
    tick();
    set_pix(1'b0, 0, 0);
    checks++;
    if (tile_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1 got tv=%0b want 0", tile_valid);
    end
    tick();
    checks++;
    if (tile_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_n2 got tv=%0b want 1", tile_valid);
    end
    tick();
    checks++;
    if (tile_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n3 got tv=%0b want 0", tile_valid);
    end
    // Sweep 256 consecutive columns across row 1.
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) set_pix(1'b1, X0 + i, Y0 + 100);
      else set_pix(1'b0, 0, 0);
      tick();
      if (i >= 1) begin
        checks++;
        if (got !== pack(e) || cell_idx[1:0] !== 2'((i - 1) / 64) || tile_u !== 6'((i - 1) % 64)) begin
          errors++;
          $display("FAIL sweep[%0d] got %h want %h (col %0d u %0d)", i - 1, got, pack(e),
                   (i - 1) / 64, (i - 1) % 64);
        end
      end
    end
  endtask

  task automatic test_edges();
    // dx, dy, tile_valid, cell_idx, u, border
    int tab[15][6] = '{
      '{ -1,  32, 0, 0,  0, 0}, '{  0,  32, 1, 0,  0, 1}, '{  1,  32, 1, 0,  1, 1},
      '{  2,  32, 1, 0,  2, 0}, '{ 61,  32, 1, 0, 61, 0}, '{ 62,  32, 1, 0, 62, 1},
      '{ 63,  32, 1, 0, 63, 1}, '{ 64,  32, 1, 1,  0, 1}, '{255,  32, 1, 3, 63, 1},
      '{256,  32, 0, 0,  0, 0}, '{100,  -1, 0, 0,  0, 0}, '{100,   0, 1, 1, 36, 1},
      '{100, 255, 1, 13, 36, 1}, '{100, 256, 0, 0,  0, 0}, '{100,   2, 1, 1, 36, 0}
    };
    for (int i = 0; i < 15; i++) begin
      set_pix(1'b1, X0 + tab[i][0], Y0 + tab[i][1]);
      tick();
      set_pix(1'b0, 0, 0);
      tick();
      checks++;
      if ({tile_valid, cell_idx, tile_u, border} !==
          {1'(tab[i][2]), 4'(tab[i][3]), 6'(tab[i][4]), 1'(tab[i][5])}) begin
        errors++;
        $display("FAIL edge[%0d] dx=%0d dy=%0d got tv=%0b idx=%0d u=%0d bd=%0b want %0d %0d %0d %0d",
                 i, tab[i][0], tab[i][1], tile_valid, cell_idx, tile_u, border,
                 tab[i][2], tab[i][3], tab[i][4], tab[i][5]);
      end
    end
  endtask

  task automatic test_simultaneous();
    set_pix(1'b0, 0, 0);
    set_cell(9, 3);
    vsync_rising_edge = 1'b1;
    repeat (2) tick();
    vsync_rising_edge = 1'b0;
    set_cell(9, 4);
    set_pix(1'b1, X0 + 64 + 20, Y0 + 128 + 20);
    tick();
    vsync_rising_edge = 1'b1;
    set_pix(1'b1, X0 + 64 + 21, Y0 + 128 + 20);
    tick();
    vsync_rising_edge = 1'b0;
    set_pix(1'b0, 0, 0);
    checks++;
    if (cell_idx !== 4'd9 || tile_exp !== 4'd3 || changed !== 1'b0) begin
      errors++;
      $display("FAIL simul_old_snap got idx=%0d exp=%0d ch=%0b want 9 3 0", cell_idx, tile_exp, changed);
    end
    tick();
    checks++;
    if (cell_idx !== 4'd9 || tile_exp !== 4'd4 || changed !== 1'b1) begin
      errors++;
      $display("FAIL simul_new_snap got idx=%0d exp=%0d ch=%0b want 9 4 1", cell_idx, tile_exp, changed);
    end
    vsync_rising_edge = 1'b1;
    tick();
    vsync_rising_edge = 1'b0;
    set_pix(1'b1, X0 + 64 + 30, Y0 + 128 + 30);
    repeat (2) tick();
    checks++;
    if (tile_exp !== 4'd4 || changed !== 1'b0) begin
      errors++;
      $display("FAIL simul_unchanged got exp=%0d ch=%0b want 4 0", tile_exp, changed);
    end
  endtask

  task automatic test_gating();
    set_pix(1'b0, X0 + 64 + 30, Y0 + 128 + 30);
    repeat (2) tick();
    checks++;
    if (got !== 23'd0) begin
      errors++;
      $display("FAIL gating got %h want 0", got);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(3) == 0) set_cell(int'($urandom_range(15)), int'($urandom_range(15)));
      vsync_rising_edge = ($urandom_range(7) == 0);
      set_pix($urandom_range(7) != 0, X0 - 20 + int'($urandom_range(300)),
              Y0 - 20 + int'($urandom_range(300)));
      tick();
      checks++;
      if (got !== pack(e) || snap_pulse !== e.sp) begin
        errors++;
        $display("FAIL random[%0d] got %h sp=%0b want %h sp=%0b", n, got, snap_pulse, pack(e), e.sp);
      end
    end
    vsync_rising_edge = 1'b0;
  endtask

  initial begin
    test_reset();
    test_snapshot_isolation();
    test_latency();
    test_edges();
    test_simultaneous();
    test_gating();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
